// File: rtl/axis_header_insert_param.sv
// Purpose : prepends a 0..W byte header (W = DATA_BYTE_WD) to each AXI-Stream
//           frame, realigning payload bytes and adding a tail beat when the
//           frame spills over.
// Latency : 1 cycle. An accepted input beat is on data_out the next cycle.
// Backpressure: registered output. ready_in follows ready_out combinationally,
//               so there is no bubble. Output holds stable while stalled.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   valid_in/ready_in        input beat handshake; data_in, keep_in, last_in
//   valid_out/ready_out      output beat handshake; data_out, keep_out, last_out
//   valid_insert/ready_insert header handshake; data_insert, keep_insert,
//                            byte_insert_cnt (expected H mod W, check only)
//   hdr_err                  one-cycle pulse when an accepted header is malformed
module axis_header_insert_param #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    valid_insert,
  output logic                    ready_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    hdr_err
);

  localparam int W  = DATA_BYTE_WD;
  // Byte counts range up to 2*W (residual plus a full beat).
  localparam int CW = $clog2(2 * W + 1);
  localparam logic [CW-1:0] W_C   = CW'(W);
  localparam logic [W-1:0]  ONE_W = W'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] TAIL   = 2'd2;

  function automatic logic [CW-1:0] popcnt(input logic [W-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Expand a per-byte enable vector into a per-bit mask.
  function automatic logic [DATA_WD-1:0] lanes(input logic [W-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  // n ones from the MSB end; n >= W gives all ones.
  function automatic logic [W-1:0] msb_ones(input logic [CW-1:0] n);
    return ~({W{1'b1}} >> n);
  endfunction

  // n ones from the LSB end; n >= W gives all ones.
  function automatic logic [W-1:0] lsb_ones(input logic [CW-1:0] n);
    return ~({W{1'b1}} << n);
  endfunction

  logic [1:0]         state;
  logic [CW-1:0]      r_cnt;     // header length R, constant for the frame
  logic [CW-1:0]      tail_cnt;  // bytes left for the tail beat
  logic [DATA_WD-1:0] res;       // residual bytes, LSB-aligned

  logic [CW-1:0]      hdr_cnt;
  logic [CW-1:0]      hdr_mod;
  logic               hdr_contig;
  logic               hdr_bad;
  logic               hs_ins;
  logic               hs_in;
  logic               out_free;
  logic [CW-1:0]      n_in;
  logic [CW-1:0]      sum;
  logic [CW+2:0]      up_sh;
  logic [CW+2:0]      dn_sh;
  logic [DATA_WD-1:0] beat_word;
  logic [DATA_WD-1:0] tail_word;
  logic [W-1:0]       beat_keep;
  logic [W-1:0]       tail_keep;
  logic               beat_last;
  logic               beat_tail;

  // Header checks: contiguity via the x & (x+1) trick, length vs expected.
  assign hdr_cnt    = popcnt(keep_insert);
  assign hdr_contig = ((keep_insert & (keep_insert + ONE_W)) == '0);
  assign hdr_mod    = (hdr_cnt == W_C) ? '0 : hdr_cnt;
  assign hdr_bad    = !hdr_contig || (hdr_mod[BYTE_CNT_WD-1:0] != byte_insert_cnt);

  // Gated by rst so nothing handshakes while reset is held.
  assign ready_insert = (state == IDLE) && !rst;
  assign hs_ins       = valid_insert && ready_insert;
  assign hdr_err      = hs_ins && hdr_bad;

  assign out_free = !valid_out || ready_out;
  assign ready_in = (state == STREAM) && out_free;
  assign hs_in    = valid_in && ready_in;

  // keep_in only matters on the last beat.
  assign n_in = last_in ? popcnt(keep_in) : W_C;
  assign sum  = r_cnt + n_in;

  // Output word = {R residual bytes, top W-R bytes of data_in}. A shift of
  // the full width yields zero, which covers R=0 and R=W without special cases.
  assign up_sh     = {W_C - r_cnt, 3'b000};
  assign dn_sh     = {r_cnt, 3'b000};
  assign beat_word = (res << up_sh) | (data_in >> dn_sh);
  assign tail_word = res << up_sh;
  assign tail_keep = msb_ones(tail_cnt);

  always_comb begin
    beat_keep = '1;
    beat_last = 1'b0;
    beat_tail = 1'b0;
    if (last_in) begin
      if (sum <= W_C) begin
        beat_keep = msb_ones(sum);
        beat_last = 1'b1;
      end else begin
        beat_tail = 1'b1;
      end
    end
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (hs_in) begin
      valid_out <= 1'b1;
      data_out  <= beat_word & lanes(beat_keep);
      keep_out  <= beat_keep;
      last_out  <= beat_last;
    end else if ((state == TAIL) && out_free) begin
      valid_out <= 1'b1;
      data_out  <= tail_word & lanes(tail_keep);
      keep_out  <= tail_keep;
      last_out  <= 1'b1;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

  // Frame FSM. It leaves STREAM/TAIL as soon as the final beat is loaded, so
  // the next header can be taken while that beat is still stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      r_cnt    <= '0;
      tail_cnt <= '0;
      res      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs_ins) begin
            res   <= data_insert & lanes(lsb_ones(hdr_cnt));
            r_cnt <= hdr_cnt;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (hs_in) begin
            res <= data_in & lanes(lsb_ones(r_cnt));
            if (last_in) begin
              if (beat_tail) begin
                tail_cnt <= sum - W_C;
                state    <= TAIL;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        TAIL: begin
          if (out_free) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_header_insert_param.sv
module tb_axis_header_insert_param;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk;
  logic        rst;
  int          w;
  logic        valid_in, last_in, valid_insert, ready_out;
  logic [63:0] data_in, data_insert;
  logic [7:0]  keep_in, keep_insert;
  logic [2:0]  byte_insert_cnt;

  logic        ready_in_a, valid_out_a, last_out_a, ready_insert_a, hdr_err_a;
  logic [31:0] data_out_a;
  logic [3:0]  keep_out_a;
  logic        ready_in_b, valid_out_b, last_out_b, ready_insert_b, hdr_err_b;
  logic [63:0] data_out_b;
  logic [7:0]  keep_out_b;

  logic        sel_a;
  logic        ready_in, valid_out, last_out, ready_insert, hdr_err;
  logic [63:0] data_out;
  logic [7:0]  keep_out;

  assign sel_a        = (w == 4);
  assign ready_in     = sel_a ? ready_in_a     : ready_in_b;
  assign valid_out    = sel_a ? valid_out_a    : valid_out_b;
  assign last_out     = sel_a ? last_out_a     : last_out_b;
  assign ready_insert = sel_a ? ready_insert_a : ready_insert_b;
  assign hdr_err      = sel_a ? hdr_err_a      : hdr_err_b;
  assign data_out     = sel_a ? {32'h0, data_out_a} : data_out_b;
  assign keep_out     = sel_a ? {4'h0, keep_out_a}  : keep_out_b;

  axis_header_insert_param #(.DATA_WD(32)) dut_a (
    .clk(clk), .rst(rst),
    .valid_in(valid_in && sel_a), .ready_in(ready_in_a),
    .data_in(data_in[31:0]), .keep_in(keep_in[3:0]), .last_in(last_in),
    .valid_out(valid_out_a), .ready_out(ready_out),
    .data_out(data_out_a), .keep_out(keep_out_a), .last_out(last_out_a),
    .valid_insert(valid_insert && sel_a), .ready_insert(ready_insert_a),
    .data_insert(data_insert[31:0]), .keep_insert(keep_insert[3:0]),
    .byte_insert_cnt(byte_insert_cnt[1:0]), .hdr_err(hdr_err_a)
  );

  axis_header_insert_param #(.DATA_WD(64)) dut_b (
    .clk(clk), .rst(rst),
    .valid_in(valid_in && !sel_a), .ready_in(ready_in_b),
    .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .valid_out(valid_out_b), .ready_out(ready_out),
    .data_out(data_out_b), .keep_out(keep_out_b), .last_out(last_out_b),
    .valid_insert(valid_insert && !sel_a), .ready_insert(ready_insert_b),
    .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .hdr_err(hdr_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  beat_t in_q[$], out_q[$], exp_q[$], stall_a[$], stall_b[$];
  int    in_cyc[$], out_cyc[$], err_cyc[$], stall_v[$];
  int    hdr_cyc;

  function automatic beat_t cur_out();
    beat_t b;
    b.d = data_out;
    b.k = keep_out;
    b.l = last_out;
    return b;
  endfunction

  function automatic logic [7:0] top_ones(input int n);
    logic [7:0] k;
    k = '0;
    for (int j = 0; j < n; j++) k[w-1-j] = 1'b1;
    return k;
  endfunction

  // Random frame of nb beats; last beat carries lastn bytes. Non-last keep
  // is random garbage, unused data lanes on the last beat are random too.
  task automatic gen_frame(input int nb, input int lastn);
    beat_t b;
    in_q.delete();
    for (int i = 0; i < nb; i++) begin
      b.d = {$urandom, $urandom};
      if (w == 4) b.d[63:32] = '0;
      b.l = (i == nb - 1);
      b.k = b.l ? top_ones(lastn) : 8'($urandom);
      in_q.push_back(b);
    end
  endtask

  // Reference: the wire is a byte sequence (header bytes then payload bytes,
  // lane W-1 first), re-chunked into W-byte beats.
  function automatic void model(input logic [63:0] hd, input logic [7:0] hk);
    logic [7:0] bq[$];
    beat_t b;
    int h, n, idx;
    h = 0;
    for (int i = 0; i < w; i++) h += int'(hk[i]);
    for (int i = h - 1; i >= 0; i--) bq.push_back(hd[8*i +: 8]);
    foreach (in_q[i]) begin
      n = in_q[i].l ? $countones(in_q[i].k) : w;
      for (int j = 0; j < n; j++) bq.push_back(in_q[i].d[8*(w-1-j) +: 8]);
    end
    exp_q.delete();
    idx = 0;
    while (idx < bq.size()) begin
      b = '0;
      for (int j = 0; j < w && idx < bq.size(); j++) begin
        b.d[8*(w-1-j) +: 8] = bq[idx];
        b.k[w-1-j] = 1'b1;
        idx++;
      end
      b.l = (idx == bq.size());
      exp_q.push_back(b);
    end
  endfunction

  // Drives one header plus in_q, records everything observed.
  // rmode: 0 ready_out=1, 1 toggling 1/0, 2 random.
  task automatic run_frame(input logic [63:0] hd, input logic [7:0] hk, input logic [2:0] hc,
                           input int gap, input int rmode, input int nexp);
    int ip, budget;
    bit hdr_done, stalled, p_ins, p_in;
    out_q.delete(); stall_a.delete(); stall_b.delete(); stall_v.delete();
    in_cyc.delete(); out_cyc.delete(); err_cyc.delete();
    hdr_cyc = -1;
    ip = 0; budget = 0; hdr_done = 0; stalled = 0; p_ins = 0; p_in = 0;
    while (out_q.size() < nexp && budget < 4000) begin
      @(negedge clk);
      if (p_ins) begin valid_insert = 1'b0; hdr_done = 1; end
      if (p_in)  begin valid_in = 1'b0; ip++; end
      if (stalled) begin stall_b.push_back(cur_out()); stall_v.push_back(int'(valid_out)); end
      case (rmode)
        0: ready_out = 1'b1;
        1: ready_out = (budget % 2 == 0);
        default: ready_out = ($urandom_range(0, 3) != 0);
      endcase
      if (!hdr_done && !valid_insert && $urandom_range(0, 99) >= gap) begin
        valid_insert = 1'b1; data_insert = hd; keep_insert = hk; byte_insert_cnt = hc;
      end
      if (ip < in_q.size() && !valid_in && $urandom_range(0, 99) >= gap) begin
        valid_in = 1'b1; data_in = in_q[ip].d; keep_in = in_q[ip].k; last_in = in_q[ip].l;
      end
      #1;
      p_ins = valid_insert && ready_insert;
      p_in  = valid_in && ready_in;
      if (p_ins) hdr_cyc = cyc;
      if (p_in) in_cyc.push_back(cyc);
      if (hdr_err) err_cyc.push_back(cyc);
      if (valid_out && ready_out) begin out_q.push_back(cur_out()); out_cyc.push_back(cyc); end
      stalled = valid_out && !ready_out;
      if (stalled) stall_a.push_back(cur_out());
      budget++;
    end
    @(negedge clk);
    valid_in = 1'b0; valid_insert = 1'b0; ready_out = 1'b0;
  endtask

  task automatic test_reset;
    for (int m = 0; m < 2; m++) begin
      w = (m == 0) ? 4 : 8;
      #1;
      tests++;
      if ({valid_out, last_out, ready_in, ready_insert, hdr_err, keep_out, data_out} !== '0) begin
        fails++;
        $display("FAIL reset_outputs w=%0d: got v=%b l=%b ri=%b rins=%b err=%b k=%h d=%h want all 0",
                 w, valid_out, last_out, ready_in, ready_insert, hdr_err, keep_out, data_out);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      w = (m == 0) ? 4 : 8;
      #0;
      tests++;
      if (ready_insert !== 1'b1 || ready_in !== 1'b0) begin
        fails++;
        $display("FAIL reset_release w=%0d: got rins=%b ri=%b want 1 0", w, ready_insert, ready_in);
      end
    end
  endtask

  task automatic test_scenario1;
    beat_t want[3];
    w = 4;
    in_q.delete();
    in_q.push_back({64'h11223344, 8'h0F, 1'b0});
    in_q.push_back({64'h55660000, 8'h0C, 1'b1});
    want[0] = {64'hAABBCC11, 8'h0F, 1'b0};
    want[1] = {64'h22334455, 8'h0F, 1'b0};
    want[2] = {64'h66000000, 8'h08, 1'b1};
    run_frame(64'h00AABBCC, 8'h07, 3'd3, 0, 0, 3);
    tests++;
    if (out_q.size() != 3) begin
      fails++; $display("FAIL s1_count: got %0d want 3", out_q.size());
    end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      tests++;
      if (out_q[i] !== want[i]) begin
        fails++; $display("FAIL s1_beat%0d: got %h want %h", i, out_q[i], want[i]);
      end
    end
    tests++;
    if (err_cyc.size() != 0) begin
      fails++; $display("FAIL s1_hdr_err: got %0d pulses want 0", err_cyc.size());
    end
  endtask

  task automatic test_passthrough;
    beat_t e;
    w = 4;
    gen_frame(3, 1);
    run_frame(64'h0, 8'h00, 3'd0, 0, 0, 3);
    tests++;
    if (out_q.size() != 3) begin
      fails++; $display("FAIL pass_count: got %0d want 3", out_q.size());
    end
    for (int i = 0; i < 3 && i < out_q.size() && i < in_cyc.size(); i++) begin
      e = in_q[i];
      e.k = (i == 2) ? 8'h08 : 8'h0F;
      if (i == 2) e.d = {32'h0, e.d[31:24], 24'h0};
      tests++;
      if (out_q[i] !== e) begin
        fails++; $display("FAIL pass_beat%0d: got %h want %h", i, out_q[i], e);
      end
      tests++;
      if (out_cyc[i] != in_cyc[i] + 1) begin
        fails++; $display("FAIL pass_latency%0d: got %0d want %0d", i, out_cyc[i] - in_cyc[i], 1);
      end
    end
  endtask

  task automatic test_full_header;
    beat_t want[2];
    w = 4;
    in_q.delete();
    in_q.push_back({64'hDEADBEEF, 8'h0E, 1'b1});
    want[0] = {64'h01020304, 8'h0F, 1'b0};
    want[1] = {64'hDEADBE00, 8'h0E, 1'b1};
    run_frame(64'h01020304, 8'h0F, 3'd0, 0, 0, 2);
    tests++;
    if (out_q.size() != 2) begin
      fails++; $display("FAIL full_hdr_count: got %0d want 2", out_q.size());
    end
    for (int i = 0; i < 2 && i < out_q.size(); i++) begin
      tests++;
      if (out_q[i] !== want[i]) begin
        fails++; $display("FAIL full_hdr_beat%0d: got %h want %h", i, out_q[i], want[i]);
      end
    end
  endtask

  task automatic test_long_w8;
    logic [63:0] hd;
    int lastn;
    w = 8;
    for (int pass = 0; pass < 2; pass++) begin
      lastn = (pass == 0) ? 7 : 5;
      hd = {$urandom, $urandom};
      gen_frame(64, lastn);
      model(hd, 8'h03);
      run_frame(hd, 8'h03, 3'd2, 0, pass, exp_q.size());
      tests++;
      if (out_q.size() != ((2 + lastn > 8) ? 65 : 64)) begin
        fails++; $display("FAIL long%0d_count: got %0d want %0d", pass, out_q.size(), (2 + lastn > 8) ? 65 : 64);
      end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
        tests++;
        if (out_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL long%0d_beat%0d: got %h want %h", pass, i, out_q[i], exp_q[i]);
        end
      end
      if (pass == 0) begin
        for (int i = 1; i < out_cyc.size(); i++) begin
          tests++;
          if (out_cyc[i] != out_cyc[i-1] + 1) begin
            fails++; $display("FAIL long_throughput%0d: got gap %0d want 1", i, out_cyc[i] - out_cyc[i-1]);
          end
        end
      end else begin
        tests++;
        if (stall_b.size() < 32) begin
          fails++; $display("FAIL long_stall_seen: got %0d stalls want >=32", stall_b.size());
        end
        for (int i = 0; i < stall_b.size(); i++) begin
          tests++;
          if (stall_b[i] !== stall_a[i] || stall_v[i] != 1) begin
            fails++; $display("FAIL long_stable%0d: got %h v=%0d want %h v=1", i, stall_b[i], stall_v[i], stall_a[i]);
          end
        end
      end
    end
  endtask

  task automatic test_hdr_err;
    logic [7:0] kt[3] = '{8'h07, 8'h05, 8'h0F};
    logic [2:0] ct[3] = '{3'd2, 3'd2, 3'd0};
    int         et[3] = '{1, 1, 0};
    logic [63:0] hd;
    w = 4;
    for (int t = 0; t < 3; t++) begin
      hd = {32'h0, $urandom};
      gen_frame(2, $urandom_range(1, 4));
      model(hd, kt[t]);
      run_frame(hd, kt[t], ct[t], 0, 0, exp_q.size());
      tests++;
      if (err_cyc.size() != et[t]) begin
        fails++; $display("FAIL hdr_err%0d_pulses: got %0d want %0d", t, err_cyc.size(), et[t]);
      end
      if (et[t] == 1 && err_cyc.size() == 1) begin
        tests++;
        if (err_cyc[0] != hdr_cyc) begin
          fails++; $display("FAIL hdr_err%0d_when: got cycle %0d want %0d", t, err_cyc[0], hdr_cyc);
        end
      end
      tests++;
      if (out_q.size() != exp_q.size()) begin
        fails++; $display("FAIL hdr_err%0d_count: got %0d want %0d", t, out_q.size(), exp_q.size());
      end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
        tests++;
        if (out_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL hdr_err%0d_beat%0d: got %h want %h", t, i, out_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] hd;
    logic [7:0]  hk;
    int h;
    for (int f = 0; f < 16; f++) begin
      w = (f % 2 == 1) ? 8 : 4;
      h = $urandom_range(0, w);
      hk = 8'((1 << h) - 1);
      hd = {$urandom, $urandom};
      if (w == 4) hd[63:32] = '0;
      gen_frame($urandom_range(1, 6), $urandom_range(1, w));
      model(hd, hk);
      run_frame(hd, hk, 3'(h % w), 30, 2, exp_q.size());
      tests++;
      if (out_q.size() != exp_q.size() || err_cyc.size() != 0) begin
        fails++; $display("FAIL rand%0d_count: got %0d beats %0d errs want %0d beats 0 errs",
                          f, out_q.size(), err_cyc.size(), exp_q.size());
      end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
        tests++;
        if (out_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL rand%0d_beat%0d: got %h want %h", f, i, out_q[i], exp_q[i]);
        end
      end
      for (int i = 0; i < stall_b.size(); i++) begin
        tests++;
        if (stall_b[i] !== stall_a[i] || stall_v[i] != 1) begin
          fails++; $display("FAIL rand%0d_stable%0d: got %h want %h", f, i, stall_b[i], stall_a[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    w = 4;
    @(negedge clk);
    ready_out = 1'b0; valid_insert = 1'b1; data_insert = '0; keep_insert = 8'h00; byte_insert_cnt = 3'd0;
    @(negedge clk);
    valid_insert = 1'b0; valid_in = 1'b1; data_in = 64'h5A123456; keep_in = 8'h08; last_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    tests++;
    if ({valid_out, last_out, keep_out, data_out, ready_insert} !== {1'b1, 1'b1, 8'h08, 64'h5A000000, 1'b1}) begin
      fails++; $display("FAIL b2b_stalled_last: got v=%b l=%b k=%h d=%h rins=%b want 1 1 08 5a000000 1",
                        valid_out, last_out, keep_out, data_out, ready_insert);
    end
    valid_insert = 1'b1; data_insert = 64'hEE; keep_insert = 8'h01; byte_insert_cnt = 3'd1;
    @(negedge clk);
    valid_insert = 1'b0; valid_in = 1'b1; data_in = 64'hAB000000; keep_in = 8'h08; last_in = 1'b1;
    #1;
    tests++;
    if (ready_in !== 1'b0 || data_out !== 64'h5A000000) begin
      fails++; $display("FAIL b2b_hold: got ri=%b d=%h want 0 5a000000", ready_in, data_out);
    end
    ready_out = 1'b1;
    #1;
    tests++;
    if (ready_in !== 1'b1) begin
      fails++; $display("FAIL b2b_ready_comb: got %b want 1", ready_in);
    end
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    tests++;
    if ({valid_out, last_out, keep_out, data_out} !== {1'b1, 1'b1, 8'h0C, 64'hEEAB0000}) begin
      fails++; $display("FAIL b2b_second: got v=%b l=%b k=%h d=%h want 1 1 0c eeab0000",
                        valid_out, last_out, keep_out, data_out);
    end
    @(negedge clk);
    #1;
    tests++;
    if (valid_out !== 1'b0) begin
      fails++; $display("FAIL b2b_drain: got %b want 0", valid_out);
    end
    ready_out = 1'b0;
  endtask

  task automatic test_reset_mid;
    w = 4;
    @(negedge clk);
    ready_out = 1'b0; valid_insert = 1'b1; data_insert = 64'h00AABBCC; keep_insert = 8'h07; byte_insert_cnt = 3'd3;
    @(negedge clk);
    valid_insert = 1'b0; valid_in = 1'b1; data_in = 64'h11223344; keep_in = 8'h0F; last_in = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    tests++;
    if (valid_out !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre: got v=%b want 1", valid_out);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({valid_out, last_out, ready_in, ready_insert, hdr_err, keep_out, data_out} !== '0) begin
      fails++; $display("FAIL rstmid_zero: got v=%b l=%b ri=%b rins=%b err=%b k=%h d=%h want all 0",
                        valid_out, last_out, ready_in, ready_insert, hdr_err, keep_out, data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (ready_insert !== 1'b1 || valid_out !== 1'b0) begin
      fails++; $display("FAIL rstmid_release: got rins=%b v=%b want 1 0", ready_insert, valid_out);
    end
    test_scenario1();
  endtask

  initial begin
    rst = 1'b1; w = 4;
    valid_in = 1'b0; last_in = 1'b0; valid_insert = 1'b0; ready_out = 1'b0;
    data_in = '0; data_insert = '0; keep_in = '0; keep_insert = '0; byte_insert_cnt = '0;
    @(negedge clk);
    test_reset();
    test_scenario1();
    test_passthrough();
    test_full_header();
    test_long_w8();
    test_hdr_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_header_insert_param.md
# axis_header_insert_param

Parametrised AXI-Stream header inserter. It prepends a 0..DATA_BYTE_WD-byte header to each frame with full ready/valid backpressure and one beat per cycle sustained throughput. Arbitrary residual-byte realignment adds a tail beat when a frame grows. It sits between packet sources and the stream egress and supersedes the fixed 32-bit inserter.

## Interface
- DATA_WD, 32, data width in bits; multiple of 8, range 16..512
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (W below)
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- valid_in / ready_in  in / out  1  input stream handshake
- data_in  in  DATA_WD  input data; byte lane W-1 (MSB) is first on the wire
- keep_in  in  DATA_BYTE_WD  byte enables; MSB-contiguous on the last beat, all ones otherwise
- last_in  in  1  last beat of the input frame
- valid_out / ready_out  out / in  1  output stream handshake
- data_out  out  DATA_WD  output data, same byte order; disabled lanes driven 0
- keep_out  out  DATA_BYTE_WD  MSB-contiguous byte enables
- last_out  out  1  last beat of the output frame
- valid_insert / ready_insert  in / out  1  header handshake, one header per frame
- data_insert  in  DATA_WD  header bytes, LSB-aligned
- keep_insert  in  DATA_BYTE_WD  header byte enables; H = popcount, 0 = no header
- byte_insert_cnt  in  BYTE_CNT_WD  expected H mod W; used for checking only
- hdr_err  out  1  one-cycle pulse on a malformed header handshake

## Operation
- FSM states: IDLE, STREAM, TAIL.
- **IDLE**
  - ready_insert=1, ready_in=0.
  - On valid_insert&&ready_insert, load the residual register with the lowest H bytes of data_insert, set R=H, go to STREAM.
- **STREAM**
  - ready_insert=0.
  - Each accepted input beat with N bytes (N=W if !last_in, else popcount(keep_in)) builds the output word as {residual R bytes, top W-R bytes of data_in}.
  - The residual becomes the low R bytes of data_in.
  - R=0 gives pure passthrough. R=W gives a header-only first beat followed by the data delayed by one beat.
  - On the last beat:
    - If R+N ≤ W, emit a single beat with keep = R+N MSB ones and last_out=1, then go to IDLE.
    - If R+N > W, emit a full beat with last_out=0, keep the R+N-W leftover bytes, and go to TAIL.
- **TAIL**
  - ready_in=0, ready_insert=0.
  - Emit the leftover beat with keep = (R+N-W) MSB ones and last_out=1, then go to IDLE.
- Header malformed when keep_insert is not LSB-contiguous, or when H mod W ≠ byte_insert_cnt:
  - hdr_err pulses for one cycle.
  - keep_insert stays authoritative: the lowest H bytes are used and the frame proceeds.
- keep_in on non-last beats is ignored and treated as all ones.
- The FSM returns to IDLE when the final beat is loaded into the output register, not when it is handshaken. The next header may be accepted while that final beat is still stalled.

## Timing
- Output is registered. An accepted input beat appears on data_out the next cycle (latency 1).
- ready_in = (state==STREAM) && (!valid_out || ready_out). Combinational from ready_out; no bubble.
- Sustained throughput is 1 beat/cycle with ready_out=1. Frame overhead is one header-handshake cycle plus an optional TAIL beat.
- Output stability: while valid_out&&!ready_out, data_out, keep_out and last_out hold stable and valid_out stays 1.
- valid_in while in IDLE or TAIL is not accepted, and no data is dropped.
- Header accepted in cycle t: ready_in may assert in cycle t+1.
- Reset asserted, effective immediately and at any point including mid-frame:
  - valid_out, data_out, keep_out, last_out, ready_in, ready_insert, hdr_err all = 0.
  - State = IDLE, R = 0.
  - Any partial frame is discarded.
- First cycle after reset release: ready_insert=1.

## Test plan
1. W=4, keep_insert=0111, data_insert=00AABBCC; frame 11223344, then 55660000 with keep 1100 and last → outputs AABBCC11/1111; 22334455/1111; 66000000/1000 with last; hdr_err=0.
2. keep_insert=0000, cnt=0; 3-beat frame with last keep 1000 → output identical to input at latency 1; no tail beat.
3. keep_insert=1111, cnt=0; single beat DEADBEEF with keep 1110 and last → outputs header beat/1111 with last=0, then DEADBE00/1110 with last.
4. 64-beat frame with H=2, W=8 (DATA_WD=64):
   - ready_out=1 → 64 output beats in consecutive cycles, plus the tail beat only when R+N>8.
   - ready_out toggling 1,0 → same data, outputs stable while stalled.
5. keep_insert=0111 with byte_insert_cnt=2 → hdr_err high for exactly one cycle at the header handshake; 3 header bytes still inserted.
6. rst pulsed mid-STREAM with valid_out=1 → all outputs 0 within the same cycle; after release ready_insert=1, and a new frame per scenario 1 produces the same expected output.
